// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the default
// oversampling ratio. The transmitter side imports the same package so both
// ends agree on the tick rate.
package uart_receiver_pkg;

    // Default number of tick pulses per bit period.
    localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/uart_receiver_rx_sync.sv
// rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so an idle (high) line never looks like a start bit
// while reset is being released.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   d_i   - asynchronous input
//   q_o   - synchronized output
module rx_sync
    import uart_receiver_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw line through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with oversampled start/data/stop
// sampling, frame-error detection and break handling.
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   tick       - one-clk oversample enable, OVERSAMPLE x baud
//   RxD        - asynchronous serial input, idle high, LSB first
//   RxD_Data   - last correctly framed byte
//   data_ready - one-clk pulse when RxD_Data is updated
//   frame_err  - one-clk pulse when the stop bit is sampled low
//   busy       - high while a frame (or break) is in progress
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       RxD,
    output logic [7:0] RxD_Data,
    output logic       data_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned      CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic           rx_s;
    uart_rx_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           ready_q, ready_d;
    logic           ferr_q, ferr_d;
    logic           busy_q, busy_d;

    rx_sync u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (RxD),
        .q_o   (rx_s)
    );

    // Next-state logic: everything advances only on tick; pulses default low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    // Re-check the line at the middle of the start bit.
                    if (cnt_q == CNT_MID) begin
                        cnt_d = CNT_ZERO;
                        bit_d = 3'd0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    // One sample per bit period, shifted in from the top.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_ZERO;
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (rx_s) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    // Hold here until the line returns high so a long low
                    // line yields a single frame error.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    bit_d   = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign RxD_Data   = data_q;
    assign data_ready = ready_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: directed frames with a frame-level model
// (expected event list + last-good-byte) checked every cycle.
module tb_uart_receiver;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       RxD;
    logic [7:0] RxD_Data;
    logic       data_ready;
    logic       frame_err;
    logic       busy;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .RxD        (RxD),
        .RxD_Data   (RxD_Data),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // Expected events, written only by the stimulus process.
    logic [7:0] exp_data [0:31];
    logic       exp_err  [0:31];
    int         n_exp = 0;
    int         pause_total = 0;
    logic       abort = 1'b0;

    // Counters owned by the stimulus process.
    int errors_m = 0;
    int checks_m = 0;
    // Counters owned by the compare process.
    int errors_c = 0;
    int checks_c = 0;
    int exp_idx = 0;
    int ready_cnt = 0;
    int ferr_cnt = 0;
    int busy_hi = 0;
    int cyc = 0;
    int ready_cyc = 0;
    logic [7:0] model_last = 8'h00;
    logic prev_rdy = 1'b0;
    logic prev_fe = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator: one tick every 4 clk; frozen while a pause is owed.
    initial begin : tick_gen
        int phase;
        int pause_done;
        phase = 0;
        pause_done = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pause_done < pause_total) begin
                pause_done++;
                tick = 1'b0;
            end else begin
                phase = (phase + 1) % 4;
                tick = (phase == 0);
            end
        end
    end

    // Compare process: checks the DUT against the frame-level model.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            checks_c++;
            if (RxD_Data !== 8'h00 || data_ready !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
                errors_c++;
                $display("FAIL reset_hold: data=%h rdy=%b ferr=%b busy=%b, required 00/0/0/0",
                         RxD_Data, data_ready, frame_err, busy);
            end
            model_last = 8'h00;
            prev_rdy = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (busy === 1'b1) busy_hi++;
            if (data_ready === 1'b1 && frame_err === 1'b1) begin
                errors_c++;
                $display("FAIL pulse_overlap: data_ready and frame_err both 1, required exclusive");
            end
            if (data_ready === 1'b1) begin
                checks_c++;
                ready_cnt++;
                ready_cyc = cyc;
                if (prev_rdy) begin
                    errors_c++;
                    $display("FAIL ready_width: data_ready high 2 cycles, required 1");
                end
                if (exp_idx >= n_exp) begin
                    errors_c++;
                    $display("FAIL unexpected_ready: data=%h, required no pulse", RxD_Data);
                end else begin
                    if (exp_err[exp_idx] || RxD_Data !== exp_data[exp_idx]) begin
                        errors_c++;
                        $display("FAIL ready_data: got data_ready data=%h, required err=%b data=%h",
                                 RxD_Data, exp_err[exp_idx], exp_data[exp_idx]);
                    end
                    model_last = exp_data[exp_idx];
                    exp_idx++;
                end
            end
            if (frame_err === 1'b1) begin
                checks_c++;
                ferr_cnt++;
                if (prev_fe) begin
                    errors_c++;
                    $display("FAIL ferr_width: frame_err high 2 cycles, required 1");
                end
                if (exp_idx >= n_exp || !exp_err[exp_idx]) begin
                    errors_c++;
                    $display("FAIL unexpected_ferr: frame_err=1, required no frame error here");
                end else begin
                    exp_idx++;
                end
            end
            checks_c++;
            if (RxD_Data !== model_last) begin
                errors_c++;
                $display("FAIL data_hold: RxD_Data=%h, required %h", RxD_Data, model_last);
            end
            prev_rdy = data_ready;
            prev_fe = frame_err;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        #1;
        for (int i = 0; i < 10; i++) begin
            if (abort) begin
                RxD = 1'b1;
                return;
            end
            RxD = bits[i];
            wait_ticks(16);
            #1;
        end
    endtask

    task automatic expect_event(input logic [7:0] b, input logic is_err);
        exp_data[n_exp] = b;
        exp_err[n_exp] = is_err;
        n_exp++;
    endtask

    task automatic check_val(input string name, input int actual, input int required);
        checks_m++;
        if (actual != required) begin
            errors_m++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, required, required);
        end
    endtask

    task automatic wait_ready(input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (ready_cnt >= target) break;
            @(posedge clk);
        end
        check_val("ready_count", ready_cnt, target);
    endtask

    initial begin : stim
        int t0;
        int lat_ref;
        int lat_p;
        int b0;
        rst_n = 1'b0;
        RxD = 1'b1;
        repeat (5) @(posedge clk);
        check_val("rst_data", int'(RxD_Data), 8'h00);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_ready", int'(data_ready), 0);
        check_val("rst_ferr", int'(frame_err), 0);
        #1 rst_n = 1'b1;
        wait_ticks(20);

        // Plain frame 0xA5.
        expect_event(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1);
        wait_ready(1, 2000);
        check_val("a5_data", int'(RxD_Data), 8'hA5);
        check_val("a5_ferr_cnt", ferr_cnt, 0);

        // Three-tick low glitch on an idle line.
        wait_ticks(20);
        b0 = busy_hi;
        #1 RxD = 1'b0;
        wait_ticks(3);
        #1 RxD = 1'b1;
        wait_ticks(20);
        checks_m++;
        if (busy_hi - b0 == 0 || busy_hi - b0 > 32) begin
            errors_m++;
            $display("FAIL glitch_busy: busy cycles %0d, required 1..32", busy_hi - b0);
        end
        check_val("glitch_busy_end", int'(busy), 0);
        check_val("glitch_ready_cnt", ready_cnt, 1);

        // Frame 0x3C with a low stop bit, then a long break.
        expect_event(8'h3C, 1'b1);
        send_frame(8'h3C, 1'b0);
        wait_ticks(40 * 16);
        check_val("break_busy", int'(busy), 1);
        #1 RxD = 1'b1;
        wait_ticks(4);
        check_val("break_busy_drop", int'(busy), 0);
        check_val("break_ferr_cnt", ferr_cnt, 1);
        check_val("break_data_kept", int'(RxD_Data), 8'hA5);

        // Back-to-back frames.
        wait_ticks(32);
        expect_event(8'h00, 1'b0);
        expect_event(8'hFF, 1'b0);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ready(3, 2000);
        check_val("b2b_data", int'(RxD_Data), 8'hFF);

        // Reset in the middle of data bit 4 of 0x55.
        wait_ticks(32);
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_ticks(16 * 5 + 4);
                #1;
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                check_val("midrst_data", int'(RxD_Data), 8'h00);
                check_val("midrst_busy", int'(busy), 0);
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        RxD = 1'b1;
        wait_ticks(200);
        check_val("midrst_no_ready", ready_cnt, 3);
        expect_event(8'h81, 1'b0);
        send_frame(8'h81, 1'b1);
        wait_ready(4, 2000);
        check_val("post_rst_data", int'(RxD_Data), 8'h81);

        // Reference 0x96 frame, then the same frame with a 100-clk tick pause.
        wait_ticks(20);
        wait_ticks(1);
        t0 = cyc;
        expect_event(8'h96, 1'b0);
        send_frame(8'h96, 1'b1);
        wait_ready(5, 2000);
        lat_ref = ready_cyc - t0;
        wait_ticks(20);
        wait_ticks(1);
        t0 = cyc;
        expect_event(8'h96, 1'b0);
        fork
            send_frame(8'h96, 1'b1);
            begin
                wait_ticks(64);
                pause_total = pause_total + 100;
            end
        join
        wait_ready(6, 2000);
        lat_p = ready_cyc - t0;
        check_val("pause_latency", lat_p, lat_ref + 100);
        check_val("pause_data", int'(RxD_Data), 8'h96);

        wait_ticks(10);
        check_val("events_consumed", exp_idx, n_exp);
        check_val("total_ferr", ferr_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors_m + errors_c, checks_m + checks_c);
        $finish;
    end

endmodule
